// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM read-port arbiter.
// Read latency of the RAM and width of the optional per-requester grant counters.
package ram_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int RD_LATENCY  = 2;
    localparam int GRANT_CNT_W = 16;

    // Width of a requester index; a single requester still gets a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_rd_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first set bit of valid_i at or after rr_ptr_i, with wrap.
// Zero latency, no state; any_o is low when no requester is valid.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] dbl_vec;
    logic [2*NUM_REQ-1:0] rot_vec;
    logic [IDW:0]         sum;

    // Rotate by the pointer so that priority becomes a plain lowest-bit-first scan.
    assign dbl_vec = {valid_i, valid_i};
    assign rot_vec = dbl_vec >> rr_ptr_i;

    always_comb begin
        any_o   = 1'b0;
        idx_o   = '0;
        grant_o = '0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_o && rot_vec[k]) begin
                any_o = 1'b1;
                sum   = {1'b0, rr_ptr_i} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NUM_REQ)) begin
                    sum = sum - (IDW+1)'(NUM_REQ);
                end
                idx_o = sum[IDW-1:0];
            end
        end
        if (any_o) begin
            grant_o = NUM_REQ'(1) << idx_o;
        end
    end

endmodule

// File: rtl/ram_rd_arbiter.sv
// Round-robin arbiter sharing the RAM read port between NUM_REQ requesters, with burst lock; optional RAM_ARB_GRANT_CNT_EN adds grant_cnt.
// Response appears RD_LATENCY cycles after accept with no backpressure; requesters see req_ready only when granted.
module ram_rd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 1024,
    parameter int NUM_REQ   = 4,
    localparam int AW       = $clog2(RAM_DEPTH),
    localparam int IDW      = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*AW-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [AW-1:0]             ram_addr_rd,
    input  logic [RAM_WIDTH-1:0]      ram_data_out,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [RAM_WIDTH-1:0]      rsp_data
`ifdef RAM_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*GRANT_CNT_W-1:0] grant_cnt
`endif
);

    arb_state_e           state_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic [IDW-1:0]       owner_q;
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [IDW-1:0]       pipe_id_q [RD_LATENCY];

    logic [NUM_REQ-1:0]   pk_grant;
    logic [IDW-1:0]       pk_idx;
    logic                 pk_any;

    logic                 accept;
    logic                 acc_last;
    logic [IDW-1:0]       acc_idx;
    logic [IDW-1:0]       rr_ptr_d;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid_i  (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pk_grant),
        .idx_o    (pk_idx),
        .any_o    (pk_any)
    );

    // Grant decision. In LOCKED the owner keeps req_ready even while idle,
    // so a dropped valid is a bubble rather than a lost lock.
    always_comb begin
        req_ready = '0;
        acc_idx   = '0;
        accept    = 1'b0;
        if (!rst) begin
            if (state_q == LOCKED) begin
                req_ready = NUM_REQ'(1) << owner_q;
                acc_idx   = owner_q;
                accept    = |(req_valid & req_ready);
            end else begin
                req_ready = pk_grant;
                acc_idx   = pk_idx;
                accept    = pk_any;
            end
        end
    end

    always_comb begin
        ram_addr_rd = '0;
        acc_last    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                ram_addr_rd = req_addr[i*AW +: AW];
                acc_last    = req_last[i];
            end
        end
    end

    assign rr_ptr_d = (acc_idx == IDW'(NUM_REQ-1)) ? '0 : acc_idx + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (accept) begin
                        rr_ptr_q <= rr_ptr_d;
                        if (!acc_last) begin
                            owner_q <= acc_idx;
                            state_q <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (accept && acc_last) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Tracks the registered RAM read; data itself is not stored, only who asked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe_id_q[s] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_id_q[0]  <= accept ? acc_idx : '0;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_id_q[s]  <= pipe_id_q[s-1];
            end
        end
    end

    assign rsp_valid = pipe_vld_q[RD_LATENCY-1];
    assign rsp_id    = pipe_id_q[RD_LATENCY-1];
    assign rsp_data  = ram_data_out;

`ifdef RAM_ARB_GRANT_CNT_EN
    logic [GRANT_CNT_W-1:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + GRANT_CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Bench for ram_rd_arbiter: directed scenarios then random traffic, checked against a rule-level model and a 2-cycle RAM model.
module tb_ram_rd_arbiter;

    localparam int NR = 4;
    localparam int AWB = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR*AWB-1:0]  req_addr;
    logic [NR-1:0]      req_last;
    logic [NR-1:0]      req_ready;
    logic [AWB-1:0]     ram_addr_rd;
    logic [7:0]         ram_data_out;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [7:0]         rsp_data;
`ifdef RAM_ARB_GRANT_CNT_EN
    logic [NR*16-1:0]   grant_cnt;
`endif

    ram_rd_arbiter #(
        .RAM_WIDTH (8),
        .RAM_DEPTH (1024),
        .NUM_REQ   (NR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .ram_addr_rd  (ram_addr_rd),
        .ram_data_out (ram_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data)
`ifdef RAM_ARB_GRANT_CNT_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // RAM with a two-register read path.
    logic [7:0] mem [1024];
    logic [7:0] ram_st1;
    always @(posedge clk) begin
        ram_st1      <= mem[ram_addr_rd];
        ram_data_out <= ram_st1;
    end

    typedef struct {
        int         t;
        int         id;
        logic [7:0] d;
    } rsp_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    rsp_t rq[$];
    int   acc_log[$];
    bit   m_locked;
    int   m_owner;
    int   m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_search(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input int addr, input bit last);
        req_valid[i]            = v;
        req_addr[i*AWB +: AWB]  = AWB'(addr);
        req_last[i]             = last;
    endtask

    // One clock: check outputs at negedge against the model, advance the model, return at posedge+1.
    task automatic run_cycle();
        int          pk;
        int          exp_acc;
        logic [3:0]  exp_rdy;
        logic [9:0]  exp_addr;
        rsp_t        e;
        @(negedge clk);
        if (rst) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
            rq.delete();
        end
        exp_rdy = '0;
        exp_acc = -1;
        if (!rst) begin
            if (m_locked) begin
                exp_rdy = 4'(1 << m_owner);
                if (req_valid[m_owner]) exp_acc = m_owner;
            end else begin
                pk = rr_search(req_valid, m_ptr);
                if (pk >= 0) begin
                    exp_rdy = 4'(1 << pk);
                    exp_acc = pk;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        exp_addr = (exp_acc >= 0) ? req_addr[exp_acc*AWB +: AWB] : 10'd0;
        chk("ram_addr_rd", 32'(ram_addr_rd), 32'(exp_addr));
        if (rq.size() > 0 && rq[0].t == cyc) begin
            e = rq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.d));
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        if (exp_acc >= 0) begin
            rq.push_back('{cyc + 2, exp_acc, mem[exp_addr]});
            acc_log.push_back(exp_acc);
            if (!m_locked) begin
                m_ptr = (exp_acc + 1) % NR;
                if (!req_last[exp_acc]) begin
                    m_locked = 1'b1;
                    m_owner  = exp_acc;
                end
            end else if (req_last[exp_acc]) begin
                m_locked = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        acc_log.delete();
    endtask

    task automatic chk_log(input string tag, input int exp[]);
        chk({tag, "_count"}, 32'(acc_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < acc_log.size()) chk(tag, 32'(acc_log[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int e2[], e3[], e4[];
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[5]    = 8'hA5;
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_last  = '1;
        m_locked  = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        #2 rst = 1'b1;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        run_cycle();
        rst = 1'b0;

        // Single read of mem[5].
        set_req(0, 1'b1, 5, 1'b1);
        run_cycle();
        req_valid = '0;
        run_cycle();
        run_cycle();
        run_cycle();
        chk_log("single_grant", '{0});

        // Round robin with everybody valid.
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 16 * i + 1, 1'b1);
        repeat (6) run_cycle();
        req_valid = '0;
        repeat (2) run_cycle();
        e2 = '{0, 1, 2, 3, 0, 1};
        chk_log("rr_order", e2);

        // Burst lock for req1 while req0/req2 wait.
        do_reset();
        set_req(0, 1'b1, 7, 1'b1);
        run_cycle();
        set_req(2, 1'b1, 300, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_req(1, 1'b1, 100 + b, (b == 3));
            run_cycle();
        end
        set_req(1, 1'b0, 0, 1'b1);
        run_cycle();
        run_cycle();
        req_valid = '0;
        repeat (2) run_cycle();
        e3 = '{0, 1, 1, 1, 1, 2, 0};
        chk_log("burst_order", e3);

        // Lock bubble: owner req3 drops valid while req0 waits.
        do_reset();
        set_req(3, 1'b1, 500, 1'b0);
        run_cycle();
        set_req(3, 1'b1, 501, 1'b0);
        run_cycle();
        set_req(3, 1'b0, 0, 1'b0);
        set_req(0, 1'b1, 9, 1'b1);
        run_cycle();
        chk("bubble_ready", 32'(req_ready), 32'h8);
        run_cycle();
        set_req(3, 1'b1, 502, 1'b0);
        run_cycle();
        set_req(3, 1'b1, 503, 1'b1);
        run_cycle();
        set_req(3, 1'b0, 0, 1'b1);
        run_cycle();
        req_valid = '0;
        repeat (2) run_cycle();
        e4 = '{3, 3, 3, 3, 0};
        chk_log("bubble_order", e4);

        // Reset while locked with reads in flight.
        do_reset();
        set_req(0, 1'b1, 40, 1'b0);
        run_cycle();
        run_cycle();
        rst = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        run_cycle();
        run_cycle();
        rst = 1'b0;
        acc_log.delete();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 60 + i, 1'b1);
        run_cycle();
        chk("post_rst_first", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'd0);
        req_valid = '0;
        repeat (2) run_cycle();

        // Random traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NR; i++) begin
                set_req(i, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)),
                        ($urandom_range(0, 2) == 0));
            end
            rst = ($urandom_range(0, 99) == 0);
            run_cycle();
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (3) run_cycle();

`ifdef RAM_ARB_GRANT_CNT_EN
        do_reset();
        set_req(2, 1'b1, 3, 1'b1);
        repeat (70000) @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("grant_cnt2_sat", 32'(grant_cnt[2*16 +: 16]), 32'hFFFF);
        chk("grant_cnt0", 32'(grant_cnt[0 +: 16]), 32'd0);
        chk("grant_cnt1", 32'(grant_cnt[16 +: 16]), 32'd0);
        chk("grant_cnt3", 32'(grant_cnt[48 +: 16]), 32'd0);
        rst = 1'b1;
        #1;
        chk("grant_cnt_clear", 32'(grant_cnt[2*16 +: 16]), 32'd0);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
